// File: rtl/program_loader_pkg.sv
// Shared types for the instruction loader: FSM state encoding and word geometry.
package program_loader_pkg;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    SYNC,
    BURST,
    FLUSH,
    RUN,
    ERROR
  } state_t;
endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs MSB-first bytes into 32-bit words; word_vld is combinational on the 4th accepted byte.
// No backpressure of its own: every i_byte_vld cycle is an accepted byte.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        i_clear,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte_dat,
  output logic        o_word_vld,
  output logic [31:0] o_word_dat
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (!Reset || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_vld) begin
      r_shift <= {r_shift[15:0], i_byte_dat};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word_vld = i_byte_vld && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word_dat = {r_shift, i_byte_dat};
endmodule

// File: rtl/program_loader.sv
// Buffers a byte stream as words, then bursts them gaplessly to the CPU; last byte at T -> first strobe T+2.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum byte after the data; rx_ready is only high while collecting.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_WORDS = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [CNT_W-1:0] prog_len,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [31:0]      Instruction,
  output logic             LoadInstructions,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WORDS);

  state_t r_state, w_next;

  logic [31:0]      r_buf [MAX_WORDS];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_len, r_count;
  logic [31:0]      r_instr;

  logic             w_load_start, w_len_ok, w_byte_vld, w_word_vld, w_last;
  logic [31:0]      w_word;
  logic [CNT_W-1:0] w_count_inc;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xsum;
`endif

  // RUN and ERROR accept a new load exactly as IDLE does.
  assign w_load_start = start && (r_state == IDLE || r_state == RUN || r_state == ERROR);
  assign w_len_ok     = (prog_len != '0) && (prog_len <= MAX_LEN);
  assign w_byte_vld   = (r_state == COLLECT) && rx_valid;
  assign w_count_inc  = r_count + CNT_W'(1);
  assign w_last       = (w_count_inc == r_len);

  byte_packer u_packer (
    .clk        (clk),
    .Reset      (Reset),
    .i_clear    (w_load_start),
    .i_byte_vld (w_byte_vld),
    .i_byte_dat (rx_data),
    .o_word_vld (w_word_vld),
    .o_word_dat (w_word)
  );

  always_ff @(posedge clk) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    rx_ready         = 1'b0;
    LoadInstructions = 1'b0;
    cpu_reset        = 1'b1;
    busy             = 1'b0;
    done             = 1'b0;
    error            = 1'b0;
    case (r_state)
      IDLE, RUN, ERROR: begin
        if (r_state == RUN)   begin cpu_reset = 1'b0; done = 1'b1; end
        if (r_state == ERROR) error = 1'b1;
        if (start) w_next = w_len_ok ? COLLECT : ERROR;
      end
      COLLECT: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (w_word_vld && w_last) w_next = CHECK;
`else
        if (w_word_vld && w_last) w_next = SYNC;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_next = (rx_data == r_xsum) ? SYNC : ERROR;
      end
`endif
      SYNC: begin
        busy   = 1'b1;
        w_next = BURST;
      end
      BURST: begin
        busy             = 1'b1;
        cpu_reset        = 1'b0;
        LoadInstructions = 1'b1;
        if (w_last) w_next = FLUSH;
      end
      FLUSH: begin
        busy   = 1'b1;
        w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset && w_byte_vld && w_word_vld) r_buf[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_instr  <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_xsum   <= '0;
`endif
    end else if (w_load_start) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_len    <= prog_len;
`ifdef LOADER_CHECKSUM_EN
      r_xsum   <= '0;
`endif
    end else begin
      case (r_state)
        COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_valid) r_xsum <= r_xsum ^ rx_data;
`endif
          if (w_word_vld) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count  <= w_count_inc;
          end
        end
        // Instruction is registered, so word k+1 is fetched while word k is on the bus.
        SYNC: begin
          r_instr  <= r_buf[0];
          r_rd_ptr <= PTR_W'(1);
          r_count  <= '0;
        end
        BURST: begin
          r_instr  <= r_buf[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          r_count  <= w_count_inc;
        end
        default: ;
      endcase
    end
  end

  assign Instruction = r_instr;
endmodule

// File: tb/tb_program_loader.sv
// Randomized directed bench for program_loader with a queue-based reference of the expected burst.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  prog_len = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] Instruction;
  logic        LoadInstructions;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int n_chk = 0;
  int n_err = 0;
  bit [31:0] exp_q[$];

  program_loader dut (
    .clk              (clk),
    .Reset            (Reset),
    .start            (start),
    .prog_len         (prog_len),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .Instruction      (Instruction),
    .LoadInstructions (LoadInstructions),
    .cpu_reset        (cpu_reset),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_load"}, LoadInstructions, 0);
    chk({tag, "_instr"}, Instruction, 0);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic fill_rand(input int n);
    exp_q.delete();
    repeat (n) exp_q.push_back($urandom);
  endtask

  // Full load of exp_q: start, byte stream (optional random gaps), then exact-cycle burst/flush/run checks.
  // poke holds a bogus start during the burst, which must be ignored.
  task automatic do_load(input int len, input bit gaps, input bit poke);
    int nbytes;
    int idx;
    int guard;
    bit [31:0] w;
    logic [7:0] b;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xs;
    xs = '0;
`endif
    nbytes = len * 4;
    idx = 0;
    guard = 0;
    start = 1'b1;
    prog_len = 6'(len);
    tick;
    start = 1'b0;
    prog_len = '0;
    while (idx < nbytes && guard < 4000) begin
      w = exp_q[idx / 4];
      b = w[31 - 8 * (idx % 4) -: 8];
      chk("collect_rx_ready", rx_ready, 1);
      chk("collect_busy", busy, 1);
      chk("collect_cpu_reset", cpu_reset, 1);
      chk("collect_load", LoadInstructions, 0);
      rx_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      rx_data  = rx_valid ? b : 8'($urandom);
      tick;
      if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
        xs = xs ^ b;
`endif
        idx++;
      end
      guard++;
    end
    chk("collect_bound", (idx == nbytes) ? 1 : 0, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("check_rx_ready", rx_ready, 1);
    rx_valid = 1'b1;
    rx_data  = xs;
    tick;
`endif
    rx_valid = 1'b0;
    chk("sync_rx_ready", rx_ready, 0);
    chk("sync_load", LoadInstructions, 0);
    chk("sync_cpu_reset", cpu_reset, 1);
    chk("sync_busy", busy, 1);
    if (poke) begin
      start = 1'b1;
      prog_len = '0;
    end
    tick;
    for (int k = 0; k < len; k++) begin
      chk("burst_load", LoadInstructions, 1);
      chk("burst_word", Instruction, exp_q[k]);
      chk("burst_cpu_reset", cpu_reset, 0);
      chk("burst_busy", busy, 1);
      tick;
    end
    start = 1'b0;
    chk("flush_load", LoadInstructions, 0);
    chk("flush_cpu_reset", cpu_reset, 1);
    chk("flush_busy", busy, 1);
    chk("flush_done", done, 0);
    tick;
    chk("run_done", done, 1);
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_busy", busy, 0);
    chk("run_error", error, 0);
    chk("run_load", LoadInstructions, 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic bad_checksum;
    bit [31:0] w;
    w = 32'h11223344;
    start = 1'b1;
    prog_len = 6'd1;
    tick;
    start = 1'b0;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = w[31 - 8 * i -: 8];
      tick;
    end
    rx_data = 8'h45;
    tick;
    rx_valid = 1'b0;
    repeat (5) begin
      chk("badsum_error", error, 1);
      chk("badsum_load", LoadInstructions, 0);
      chk("badsum_cpu_reset", cpu_reset, 1);
      tick;
    end
  endtask
`endif

  initial begin
    // Reset and idle
    repeat (2) tick;
    chk_reset_vals("reset");
    Reset = 1'b1;
    tick;
    chk_reset_vals("idle");

    // Directed two-word program
    exp_q = '{32'h20010005, 32'h20020007};
    do_load(2, 1'b0, 1'b0);

    // prog_len=0 from RUN -> ERROR, never loads
    start = 1'b1;
    prog_len = 6'd0;
    tick;
    start = 1'b0;
    chk("len0_error", error, 1);
    chk("len0_busy", busy, 0);
    chk("len0_done", done, 0);
    chk("len0_rx_ready", rx_ready, 0);
    repeat (3) begin
      tick;
      chk("len0_load", LoadInstructions, 0);
      chk("len0_cpu_reset", cpu_reset, 1);
    end

    // Oversized length from ERROR stays in ERROR
    start = 1'b1;
    prog_len = 6'd33;
    tick;
    start = 1'b0;
    chk("len33_error", error, 1);
    chk("len33_busy", busy, 0);

    // Full-depth load with random valid gaps, start poked during burst
    fill_rand(32);
    do_load(32, 1'b1, 1'b1);

    // Reset mid-collect after 5 bytes of a 3-word load
    fill_rand(3);
    start = 1'b1;
    prog_len = 6'd3;
    tick;
    start = 1'b0;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'($urandom);
      tick;
    end
    rx_valid = 1'b0;
    Reset = 1'b0;
    tick;
    chk_reset_vals("midreset");
    Reset = 1'b1;
    tick;
    fill_rand(3);
    do_load(3, 1'b1, 1'b0);

    // Bytes offered in RUN are ignored
    rx_valid = 1'b1;
    repeat (3) begin
      rx_data = 8'($urandom);
      tick;
      chk("run_rx_ignored_ready", rx_ready, 0);
      chk("run_rx_ignored_done", done, 1);
    end
    rx_valid = 1'b0;

    // Reload from RUN with a single zero word
    exp_q = '{32'h00000000};
    do_load(1, 1'b1, 1'b0);

    // Random lengths
    repeat (4) begin
      int len;
      len = $urandom_range(1, 32);
      fill_rand(len);
      do_load(len, 1'b1, $urandom_range(0, 1) == 1);
    end

`ifdef LOADER_CHECKSUM_EN
    exp_q = '{32'h11223344};
    do_load(1, 1'b0, 1'b0);
    bad_checksum();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
